// File: rtl/seg7_pkg.sv
// Shared seven-segment constants and the nibble decode helper.
// Segment vectors are ordered [0:6] = a..g and are active-low.
package seg7_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [0:6] SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [0:6] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational hex nibble to active-low seven-segment decode.
// Reusable by any display user that needs the standard glyph set.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver with shadow
// registers, leading-zero blanking, per-digit decimal points and registered pins.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    blank_lz,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    dp
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX  = IW'(NUM_DIGITS - 1);

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_num_digits
    $error("seg7_scan_driver: NUM_DIGITS must be in 1..8");
  end
  if (REFRESH_DIV < 1) begin : g_bad_refresh_div
    $error("seg7_scan_driver: REFRESH_DIV must be >= 1");
  end

  logic [4*NUM_DIGITS-1:0] val_q, val_d;
  logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;
  logic                    blz_q, blz_d;
  logic [PW-1:0]           pcnt_q, pcnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [0:6]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    dp_q, dp_d;

  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    upper_zero;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    cur_dp;
  logic [0:6]              dec_seg;

  always_comb begin
    val_d = load ? value    : val_q;
    dpm_d = load ? dp_mask  : dpm_q;
    blz_d = load ? blank_lz : blz_q;
  end

  // Prescaler and digit index both freeze while the display is disabled.
  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    if (enable) begin
      if (pcnt_q == PCNT_MAX) begin
        pcnt_d = '0;
        idx_d  = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
        pcnt_d = pcnt_q + 1'b1;
      end
    end
  end

  // Scan from the most significant digit down; digit 0 is never blanked.
  always_comb begin
    blank_vec  = '0;
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & (val_q[4*i +: 4] == 4'h0);
      blank_vec[i] = blz_q & upper_zero & (i != 0);
    end
  end

  always_comb begin
    cur_nib   = 4'h0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib   = val_q[4*i +: 4];
        cur_blank = blank_vec[i];
        cur_dp    = dpm_q[i];
      end
    end
  end

  hex7seg u_hex7seg (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_d = SEG_BLANK;
    an_d  = '1;
    dp_d  = 1'b1;
    if (enable) begin
      seg_d = cur_blank ? SEG_BLANK : dec_seg;
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      dp_d  = ~cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_q  <= '0;
      dpm_q  <= '0;
      blz_q  <= 1'b0;
      pcnt_q <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_BLANK;
      an_q   <= '1;
      dp_q   <= 1'b1;
    end else begin
      val_q  <= val_d;
      dpm_q  <= dpm_d;
      blz_q  <= blz_d;
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a 4-digit/div-3 and a 1-digit/div-1 instance
// share stimulus and are compared every cycle against a cycle-count model.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_mask = '0;
  logic        blank_lz = 1'b0;

  logic [0:6]  seg4, seg1;
  logic [3:0]  an4;
  logic [0:0]  an1;
  logic        dp4, dp1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(3)) u_dut4 (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .value(value), .dp_mask(dp_mask), .blank_lz(blank_lz),
    .seg(seg4), .an(an4), .dp(dp4)
  );

  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .load(load),
    .value(value[3:0]), .dp_mask(dp_mask[0:0]), .blank_lz(blank_lz),
    .seg(seg1), .an(an1), .dp(dp1)
  );

  // Glyph table written out independently, bit 6 = segment a.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int unsigned nd [2] = '{4, 1};
  int unsigned dv [2] = '{3, 1};
  logic [31:0] m_val [2];
  logic [7:0]  m_dpm [2];
  logic        m_blz [2];
  int unsigned m_cnt [2];   // enabled cycles since reset
  logic [6:0]  e_seg [2];
  logic [7:0]  e_an  [2];
  logic        e_dp  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Expected pins after the coming edge, from the inputs about to be sampled.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        e_seg[k] = 7'h7F; e_an[k] = 8'hFF; e_dp[k] = 1'b1;
        m_val[k] = '0; m_dpm[k] = '0; m_blz[k] = 1'b0; m_cnt[k] = 0;
      end else begin
        if (enable) begin
          int unsigned idx;
          logic [31:0] rest;
          idx  = (m_cnt[k] / dv[k]) % nd[k];
          rest = m_val[k] >> (4 * idx);
          if (m_blz[k] && idx > 0 && rest == 0) e_seg[k] = 7'h7F;
          else e_seg[k] = seg_tab[rest[3:0]];
          e_an[k] = ~(8'd1 << idx);
          e_dp[k] = ~m_dpm[k][idx];
          m_cnt[k]++;
        end else begin
          e_seg[k] = 7'h7F; e_an[k] = 8'hFF; e_dp[k] = 1'b1;
        end
        if (load) begin
          m_val[k] = 32'(value) & ((32'd1 << (4 * nd[k])) - 1);
          m_dpm[k] = 8'(dp_mask) & 8'((1 << nd[k]) - 1);
          m_blz[k] = blank_lz;
        end
      end
      e_an[k] = e_an[k] & 8'((1 << nd[k]) - 1);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic l,
                     input logic [15:0] v, input logic [3:0] m, input logic b);
    @(negedge clk);
    rst = r; enable = e; load = l; value = v; dp_mask = m; blank_lz = b;
    model_edge();
    @(posedge clk);
    #1;
    check("seg4", 32'(seg4), 32'(e_seg[0]));
    check("an4",  32'(an4),  32'(e_an[0]));
    check("dp4",  32'(dp4),  32'(e_dp[0]));
    check("seg1", 32'(seg1), 32'(e_seg[1]));
    check("an1",  32'(an1),  32'(e_an[1]));
    check("dp1",  32'(dp1),  32'(e_dp[1]));
  endtask

  task automatic run(input int n, input logic e);
    for (int i = 0; i < n; i++) cyc(1'b0, e, 1'b0, value, dp_mask, blank_lz);
  endtask

  function automatic logic [15:0] rand_val();
    logic [15:0] v;
    for (int d = 0; d < 4; d++)
      v[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    // Basic scan of 12AF.
    cyc(1'b0, 1'b1, 1'b1, 16'h12AF, 4'h0, 1'b0);
    run(14, 1'b1);
    // Leading-zero blanking on and off, then all-zero value.
    cyc(1'b0, 1'b1, 1'b1, 16'h0040, 4'h0, 1'b1);
    run(13, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0040, 4'h0, 1'b0);
    run(13, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h0000, 4'h0, 1'b1);
    run(13, 1'b1);
    // Decimal point on digit 2 only.
    cyc(1'b0, 1'b1, 1'b1, 16'h5678, 4'b0100, 1'b0);
    run(13, 1'b1);
    // Mid-dwell load, back-to-back loads.
    cyc(1'b0, 1'b1, 1'b1, 16'h9ABC, 4'h0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'hDEF0, 4'h3, 1'b1);
    run(7, 1'b1);
    // Reset together with load during a scan.
    cyc(1'b1, 1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1);
    run(14, 1'b1);
    // Enable drop and recovery.
    cyc(1'b0, 1'b1, 1'b1, 16'h4321, 4'h1, 1'b0);
    run(4, 1'b1);
    run(5, 1'b0);
    run(8, 1'b1);
    // Every nibble through both instances.
    for (int n = 0; n < 16; n++) begin
      cyc(1'b0, 1'b1, 1'b1, {4'($urandom_range(0, 15)), 8'h00, 4'(n)}, 4'($urandom_range(0, 15)), 1'b1);
      run(2, 1'b1);
    end
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 60) == 0), ($urandom_range(0, 7) != 0),
          ($urandom_range(0, 5) == 0), rand_val(), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed driver for an N-digit common-anode seven-segment display.
- Latches an N-digit hexadecimal word on a load strobe and scans the digits one at a time, each for a programmable dwell.
- Adds optional leading-zero blanking and a per-digit decimal-point mask.
- Sits between the arithmetic datapath (adder/subtractor, complementer) and the board display pins.
- Replaces the single-digit, fixed-anode combinational decoder.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 65536, clock cycles each digit stays active; legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = scan running; 0 = display dark, scan frozen.
- load  input  1  1-cycle strobe; captures value, dp_mask and blank_lz.
- value  input  4*NUM_DIGITS  hex digits; digit i = value[4i+3:4i], digit 0 is rightmost.
- dp_mask  input  NUM_DIGITS  1 = light the decimal point of digit i.
- blank_lz  input  1  1 = blank leading zero digits.
- seg  output  [0:6]  segments a..g, active-low.
- an  output  NUM_DIGITS  anode selects, active-low, one-hot-low when lit.
- dp  output  1  decimal point, active-low.

## Operation
- Shadow registers val_q, dpm_q and blz_q load on any cycle with load=1.
- Outputs only ever use the shadow registers, never the live inputs.
- Prescaler pcnt counts 0..REFRESH_DIV-1 while enable=1 and holds while enable=0.
- Digit index idx increments modulo NUM_DIGITS on the cycle pcnt wraps (REFRESH_DIV-1 → 0).
- With REFRESH_DIV=1, idx advances every cycle.
- Load does not disturb pcnt or idx. The new value appears on the next output update, with no glitch on the current digit's anode.
- Decode, as seg[0:6], with 0 = segment on:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Leading-zero blanking: with blz_q=1, digit i>0 is blanked when digits i..NUM_DIGITS-1 are all zero.
  - Blanked means seg=1111111 and dp still follows dpm_q[i]; an[i] still goes low.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Outputs while enable=1: an = ~(1<<idx), seg = decode/blank of digit idx, dp = ~dpm_q[idx].
- Outputs while enable=0: an all ones, seg=1111111, dp=1.

## Timing
- seg, an and dp are registered: they reflect idx, the shadow registers and enable as of the previous cycle (1-cycle latency).
- Reset (rst=1 at an edge) sets:
  - val_q=0, dpm_q=0, blz_q=0
  - pcnt=0, idx=0
  - an=all ones, seg=1111111, dp=1
- Reset mid-scan aborts immediately; no partial digit is carried over.
- First lit output: the cycle after the first edge with rst=0 and enable=1; digit 0 is shown for REFRESH_DIV cycles.
- rst and load asserted in the same cycle: reset wins and the load is lost.
- enable falling: the display goes dark on the next edge and pcnt and idx hold.
- enable rising: scanning resumes at the held idx/pcnt.
- load asserted on consecutive cycles: the last one wins.
- idx wrap NUM_DIGITS-1 → 0 happens in a single step, with no idle slot.

## Structure
- Package seg7_pkg holds:
  - constant SEG_BLANK = 7'b1111111
  - the 16-entry decode constant table
  - function hex_to_seg(logic [3:0]) returning logic [0:6]
- Sub-module hex7seg: combinational nibble → segment decode wrapping hex_to_seg. One instance in seg7_scan_driver; the same block is reusable by other display users.
- Top-level contents: prescaler, idx counter, shadow registers, leading-zero detector (priority scan from the MSD down) and output registers.
- Add elaboration-time assertions on the parameter ranges.

## Test plan
1. NUM_DIGITS=4, REFRESH_DIV=3: reset, enable=1, load value=16'h12AF, dp_mask=0.
   - an cycles 1110, 1101, 1011, 0111, each for 3 cycles.
   - seg is 0111000 (F), 0001000 (A), 0010010 (2), 1001111 (1) respectively.
2. Load 16'h0040 with blank_lz=1, then with blank_lz=0.
   - Digits 3 and 2 show seg=1111111 with blanking on; digit 1 shows 1001100 and digit 0 shows 0000001.
   - With blanking off, digits 3 and 2 show 0000001.
   - Load 16'h0000 with blank_lz=1: only digit 0 shows 0000001.
3. dp_mask=4'b0100: dp=0 only while an=1011; dp=1 on every other digit.
4. Load new value in mid-dwell of digit 2.
   - idx and pcnt are unchanged.
   - seg switches to the new digit 2 code exactly 1 cycle after the load edge.
5. Assert rst during digit 3, together with load.
   - Next cycle: an=1111, seg=1111111, dp=1; val_q=0.
   - After release: digit 0 shows 0000001 for 3 cycles.
6. NUM_DIGITS=1, REFRESH_DIV=1: an is constantly 0 once enabled.
   - Drop enable for 5 cycles: an=1 for 5 cycles, then recovers.
   - Exhaustive nibbles 0..F each match the decode table.
